// File: rtl/muldiv_unit_if.sv
// Handshake and result bundle between the control path and the multiply/divide unit.
// The control path is the master and the unit is the slave.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op_div;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op_div, src_a, src_b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op_div, src_a, src_b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned MULTU/DIVU unit: shift-add multiply and restoring divide, one bit per cycle.
// The HI/LO result registers are updated only when an operation finishes.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  muldiv_unit_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t             state_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               div_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  // Multiplicand for MULTU, divisor for DIVU.
  logic [WIDTH-1:0]   opnd_reg;
  logic [2*WIDTH-1:0] prod_reg;
  logic [WIDTH:0]     rem_reg;
  logic [WIDTH-1:0]   quot_reg;

  logic [WIDTH:0]     sum_next;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH+1:0]   rem_shift;
  logic [WIDTH+1:0]   diff;
  logic [WIDTH:0]     rem_next;
  logic [WIDTH-1:0]   quot_next;

  always_comb begin
    sum_next  = {1'b0, prod_reg[2*WIDTH-1:WIDTH]}
              + (prod_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
    prod_next = {sum_next, prod_reg[WIDTH-1:1]};

    // Extra top bit makes the trial subtraction's sign visible.
    rem_shift = {rem_reg, quot_reg[WIDTH-1]};
    diff      = rem_shift - {2'b00, opnd_reg};
    if (!diff[WIDTH+1]) begin
      rem_next  = diff[WIDTH:0];
      quot_next = {quot_reg[WIDTH-2:0], 1'b1};
    end else begin
      rem_next  = rem_shift[WIDTH:0];
      quot_next = {quot_reg[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      div_reg   <= 1'b0;
      cnt_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      opnd_reg  <= '0;
      prod_reg  <= '0;
      rem_reg   <= '0;
      quot_reg  <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // busy_reg still high here means FINISH just retired; hold off one cycle.
          busy_reg <= 1'b0;
          if (bus.start && !busy_reg) begin
            div_reg   <= bus.op_div;
            opnd_reg  <= bus.op_div ? bus.src_b : bus.src_a;
            prod_reg  <= {{WIDTH{1'b0}}, bus.src_b};
            rem_reg   <= '0;
            quot_reg  <= bus.src_a;
            cnt_reg   <= CNT_W'(WIDTH - 1);
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          busy_reg <= 1'b1;
          if (div_reg) begin
            rem_reg  <= rem_next;
            quot_reg <= quot_next;
          end else begin
            prod_reg <= prod_next;
          end
          if (cnt_reg == '0) begin
            state_reg <= FINISH;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        FINISH: begin
          busy_reg <= 1'b1;
          done_reg <= 1'b1;
          if (div_reg) begin
            hi_reg <= rem_reg[WIDTH-1:0];
            lo_reg <= quot_reg;
          end else begin
            hi_reg <= prod_reg[2*WIDTH-1:WIDTH];
            lo_reg <= prod_reg[WIDTH-1:0];
          end
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, results, busy protection and mid-operation reset.
// Expected values are hand-computed constants; one line printed per transaction.
module tb_muldiv_unit;

  localparam int W = 32;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  muldiv_unit_if #(.WIDTH(W)) bus();

  muldiv_unit #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] prev_hi = '0;
  logic [W-1:0] prev_lo = '0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch one operation and follow it to IDLE; inj_idx >= 0 pulses a 9/2 divide start mid-run.
  task automatic run_op(input string tag, input logic div, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo, input int inj_idx);
    int idx, done_idx, busy_cnt, done_cnt;
    logic hold_ok;
    @(negedge clock);
    bus.start  = 1'b1;
    bus.op_div = div;
    bus.src_a  = a;
    bus.src_b  = b;
    @(posedge clock);
    idx = 0; done_idx = -1; busy_cnt = 0; done_cnt = 0; hold_ok = 1'b1;
    while (idx < 60) begin
      @(negedge clock);
      if (idx == 0) begin
        bus.start = 1'b0;
        bus.src_a = $urandom;
        bus.src_b = $urandom;
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_idx < 0) done_idx = idx;
      end else if (bus.busy && (bus.hi !== prev_hi || bus.lo !== prev_lo)) begin
        hold_ok = 1'b0;
      end
      if (idx == inj_idx) begin
        bus.start  = 1'b1;
        bus.op_div = 1'b1;
        bus.src_a  = 32'd9;
        bus.src_b  = 32'd2;
      end else if (idx == inj_idx + 1) begin
        bus.start = 1'b0;
      end
      if (!bus.busy) break;
      idx++;
    end
    bus.start = 1'b0;
    check({tag, " no_timeout"}, 32'(idx < 60), 32'd1);
    check({tag, " done_latency"}, 32'(done_idx), 32'd33);
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd34);
    check({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, " hold_during_run"}, 32'(hold_ok), 32'd1);
    check({tag, " hi"}, bus.hi, exp_hi);
    check({tag, " lo"}, bus.lo, exp_lo);
    $display("txn %s: a=%h b=%h div=%0d -> hi=%h lo=%h (done@%0d busy=%0d)",
             tag, a, b, div, bus.hi, bus.lo, done_idx, busy_cnt);
    prev_hi = exp_hi;
    prev_lo = exp_lo;
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.op_div = 1'b0;
    bus.src_a  = '0;
    bus.src_b  = '0;

    @(negedge clock);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset hi", bus.hi, 32'd0);
    check("reset lo", bus.lo, 32'd0);
    $display("txn reset: busy=%0d done=%0d hi=%h lo=%h", bus.busy, bus.done, bus.hi, bus.lo);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    run_op("mul_7x6",   1'b0, 32'd7,          32'd6,          32'h00000000, 32'h0000002A, -1);
    run_op("mul_max",   1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 32'h00000001, -1);
    run_op("div_100_7", 1'b1, 32'd100,        32'd7,          32'd2,        32'd14,       -1);
    run_op("div_msb_3", 1'b1, 32'h80000000,   32'h00000003,   32'd2,        32'h2AAAAAAA, -1);
    run_op("div_by_0",  1'b1, 32'd5,          32'd0,          32'd5,        32'hFFFFFFFF, -1);
    run_op("mul_busy",  1'b0, 32'd7,          32'd6,          32'h00000000, 32'h0000002A, 10);

    // Abort a multiply at cycle 15 with an asynchronous reset.
    @(negedge clock);
    bus.start  = 1'b1;
    bus.op_div = 1'b0;
    bus.src_a  = 32'h00001234;
    bus.src_b  = 32'h00000010;
    @(posedge clock);
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      bus.start = 1'b0;
    end
    check("abort busy_before", 32'(bus.busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort hi", bus.hi, 32'd0);
    check("abort lo", bus.lo, 32'd0);
    $display("txn abort: busy=%0d done=%0d hi=%h lo=%h", bus.busy, bus.done, bus.hi, bus.lo);
    prev_hi = '0;
    prev_lo = '0;
    @(negedge clock);
    reset_n = 1'b1;

    run_op("mul_3x3", 1'b0, 32'd3, 32'd3, 32'd0, 32'd9, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative unsigned multiply/divide unit that executes the MULTU and DIVU operations decoded by the control unit and holds the HI/LO result registers read by MFHI/MFLO. It sits in the execute stage beside the ALU. It accepts one operation per start pulse, runs for a fixed number of cycles, then updates HI/LO. While it runs, it asserts `busy` so the control path can stall any dependent MFHI/MFLO or new MULTU/DIVU.

## Interface
- `WIDTH`, default 32: operand and HI/LO width; iteration count equals `WIDTH`.
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch request, one-cycle pulse from control; sampled only in IDLE.
- `op_div`  in  1  operation select at start: 0 = MULTU, 1 = DIVU.
- `src_a`  in  `WIDTH`  rs operand, captured at accepted start (multiplicand / dividend).
- `src_b`  in  `WIDTH`  rt operand, captured at accepted start (multiplier / divisor).
- `busy`  out  1  high while an operation is in progress; `start` is ignored while high.
- `done`  out  1  one-cycle pulse in the cycle HI/LO first show the new result.
- `hi`  out  `WIDTH`  HI register: product upper half, or remainder.
- `lo`  out  `WIDTH`  LO register: product lower half, or quotient.

## Operation
- States: IDLE, RUN, FINISH.
- IDLE: `busy`=0. If `start`=1, then:
  - capture `src_a`, `src_b` and `op_div`;
  - clear the working accumulator;
  - load the iteration counter with `WIDTH`-1;
  - go to RUN.
- RUN: `busy`=1. Perform one iteration per cycle and decrement the counter. When the counter reaches 0, go to FINISH after completing that iteration.
- Multiply uses shift-add.
  - Working state is a 2×`WIDTH` product register: upper half is the accumulator, lower half is the multiplier.
  - Each cycle, if the multiplier LSB is 1, add the multiplicand to the upper half with carry kept in a `WIDTH`+1 bit sum. Then shift the whole {carry, product} right by 1.
- Divide uses restoring division.
  - Working state is a remainder (`WIDTH`+1 bits) and a quotient (`WIDTH` bits).
  - Each cycle, shift {rem, quot} left by 1, then trial-subtract the divisor from rem.
  - If the result is non-negative, keep it and set quot LSB to 1. Otherwise restore rem and set quot LSB to 0.
- FINISH: `busy`=1. Write the result to HI/LO, assert `done` for this cycle, then return to IDLE.
  - Multiply: `hi` = product[2W-1:W], `lo` = product[W-1:0].
  - Divide: `hi` = remainder, `lo` = quotient.
- Divide by zero is not trapped. It runs the normal 32 iterations, giving `lo` = all ones and `hi` = `src_a`.
- `hi`/`lo` change only in FINISH. They hold the previous result during RUN, so MFHI/MFLO issued before a new start reads the old value.
- `start` while `busy`=1 is dropped, not queued. Operand inputs are don't-care after the start cycle.

## Timing
- Reset (async, immediate on `reset_n` low):
  - state = IDLE;
  - `busy`=0, `done`=0;
  - `hi`=0, `lo`=0;
  - counter and working registers = 0.
- Reset asserted mid-operation aborts the operation with no HI/LO update; the next start after release behaves normally.
- Latency, with the start accepted at edge 0:
  - `busy` rises after edge 0;
  - RUN occupies cycles 1..`WIDTH`;
  - FINISH is cycle `WIDTH`+1; `done`=1 and new `hi`/`lo` are visible after edge `WIDTH`+1;
  - `busy` falls after edge `WIDTH`+2.
- Total: `WIDTH`+2 cycles from start edge to IDLE; 34 for `WIDTH`=32.
- Back-to-back operation: the earliest next start is accepted on the edge where `busy` is observed 0, which is one cycle after `done`.
- `done` and `busy` are both high in the FINISH cycle. The control path must treat HI/LO as readable from the cycle after `done`.

## Test plan
- Multiply basic: reset, then `start`, `op_div`=0, `src_a`=7, `src_b`=6 → `done` 33 cycles after the start edge, `hi`=0x00000000, `lo`=0x0000002A; `busy` high for exactly 34 cycles.
- Multiply maximum carry: 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- Divide: 100 ÷ 7 → `lo`=14, `hi`=2; 0x80000000 ÷ 0x00000003 → `lo`=0x2AAAAAAA, `hi`=2.
- Divide by zero: 5 ÷ 0 → `lo`=0xFFFFFFFF, `hi`=5, normal latency, no hang.
- Busy protection:
  - start 7×6, then pulse `start` with 9÷2 at cycle 10 → ignored; result stays 0/42 and only one `done` pulse occurs;
  - `hi`/`lo` hold their prior values throughout RUN.
- Reset mid-operation: start 0x1234×0x10, drop `reset_n` at cycle 15 → `busy`, `done`, `hi`, `lo` go to 0 immediately; after release, start 3×3 → `lo`=9 with normal latency.
